gate_delay_bank: RTL and testbench

- Parametrised, clocked successor to the single-channel digital inverter model used for mixed-signal co-simulation.
- Models CH independent inverter or buffer channels, each with its own rise and fall delay in clock cycles.
- Uses inertial (glitch-rejecting) delay semantics and emits a per-channel change strobe, which replaces the old per-event sync call.
- Also keeps a saturating count of rejected glitches so the bench can log pulse filtering.

---
 rtl/gate_delay_bank.sv | 148 ++++++++++++++
 tb/tb_gate_delay_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_delay_bank.sv
// gate_delay_bank: CH independent clocked inverter/buffer channels with
// separate rise/fall delays, inertial (glitch-rejecting) delay semantics,
// a registered per-channel change strobe, and a saturating count of
// cancelled transitions.
module gate_delay_bank #(
  parameter int unsigned CH       = 4,
  parameter bit          INVERT   = 1'b1,
  parameter int unsigned RISE_CYC = 3,
  parameter int unsigned FALL_CYC = 2,
  parameter bit          INIT_V   = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    in,
  input  logic             clr_cnt,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    chg,
  output logic [CH-1:0]    pend,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned MAXD = (RISE_CYC > FALL_CYC) ? RISE_CYC : FALL_CYC;
  localparam int unsigned DW   = (MAXD < 2) ? 1 : $clog2(MAXD + 1);
  localparam int unsigned PW   = $clog2(CH + 1);
  localparam int unsigned SW   = ((CNT_W > PW) ? CNT_W : PW) + 1;

  localparam logic [DW-1:0]    RISE_D  = DW'(RISE_CYC);
  localparam logic [DW-1:0]    FALL_D  = DW'(FALL_CYC);
  localparam logic [DW-1:0]    ONE_D   = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ch_state_e;

  ch_state_e        state_q [CH];
  ch_state_e        state_d [CH];
  logic [DW-1:0]    cnt_q   [CH];
  logic [DW-1:0]    cnt_d   [CH];
  logic [CH-1:0]    out_q, out_d;
  logic [CH-1:0]    chg_q, chg_d;
  logic [CH-1:0]    cancel;
  logic [CH-1:0]    tgt;
  logic [CNT_W-1:0] glitch_q, glitch_d;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;

  assign tgt = INVERT ? ~in : in;

  // Per-channel inertial delay: commit after D consecutive differing samples,
  // cancel (and flag a glitch) if the target reverts before that.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      out_d[i]   = out_q[i];
      chg_d[i]   = 1'b0;
      cancel[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (tgt[i] != out_q[i]) begin
            if ((tgt[i] ? RISE_D : FALL_D) == ONE_D) begin
              out_d[i] = tgt[i];
              chg_d[i] = 1'b1;
            end else begin
              state_d[i] = PENDING;
              cnt_d[i]   = ONE_D;
            end
          end
        end
        PENDING: begin
          if (tgt[i] != out_q[i]) begin
            // Delay cannot change while pending: a different target would
            // equal out and take the cancel branch instead.
            if ((cnt_q[i] + ONE_D) == (tgt[i] ? RISE_D : FALL_D)) begin
              out_d[i]   = tgt[i];
              chg_d[i]   = 1'b1;
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_D;
            end
          end else begin
            cancel[i]  = 1'b1;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear wins over same-edge cancellations.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pop = pop + PW'(cancel[i]);
    end
    sum = SW'(glitch_q) + SW'(pop);
    if (clr_cnt) begin
      glitch_d = '0;
    end else if (sum > SW'(CNT_MAX)) begin
      glitch_d = CNT_MAX;
    end else begin
      glitch_d = sum[CNT_W-1:0];
    end
  end

  // State, output and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_q    <= {CH{INIT_V}};
      chg_q    <= '0;
      glitch_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q    <= out_d;
      chg_q    <= chg_d;
      glitch_q <= glitch_d;
    end
  end

  // Pending flag is a direct decode of the registered channel state.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pend[i] = (state_q[i] == PENDING);
    end
  end

  assign out        = out_q;
  assign chg        = chg_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_gate_delay_bank.sv
// Directed bench for gate_delay_bank: main inverter bank (rise 3 / fall 2),
// a 4-bit-counter copy for saturation, and a unit-delay buffer copy.
module tb_gate_delay_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in;
  logic        clr_cnt;

  logic [3:0]  out_m, chg_m, pend_m;
  logic [15:0] gc_m;
  logic [3:0]  out_s, chg_s, pend_s;
  logic [3:0]  gc_s;
  logic [3:0]  out_b, chg_b, pend_b;
  logic [15:0] gc_b;

  int unsigned n_chk;
  int unsigned n_err;

  gate_delay_bank #(
    .CH(4), .INVERT(1'b1), .RISE_CYC(3), .FALL_CYC(2), .INIT_V(1'b1), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .clr_cnt(clr_cnt),
    .out(out_m), .chg(chg_m), .pend(pend_m), .glitch_cnt(gc_m)
  );

  gate_delay_bank #(
    .CH(4), .INVERT(1'b1), .RISE_CYC(3), .FALL_CYC(2), .INIT_V(1'b1), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .clr_cnt(clr_cnt),
    .out(out_s), .chg(chg_s), .pend(pend_s), .glitch_cnt(gc_s)
  );

  gate_delay_bank #(
    .CH(4), .INVERT(1'b0), .RISE_CYC(1), .FALL_CYC(1), .INIT_V(1'b0), .CNT_W(16)
  ) u_buf (
    .clk(clk), .rst_n(rst_n), .in(in), .clr_cnt(clr_cnt),
    .out(out_b), .chg(chg_b), .pend(pend_b), .glitch_cnt(gc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [3:0] o, input logic [3:0] c,
                          input logic [3:0] p, input logic [15:0] g);
    check({tag, ".out"},  32'(out_m),  32'(o));
    check({tag, ".chg"},  32'(chg_m),  32'(c));
    check({tag, ".pend"}, 32'(pend_m), 32'(p));
    check({tag, ".gcnt"}, 32'(gc_m),   32'(g));
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    in      = 4'b0000;
    clr_cnt = 1'b0;

    // Reset state, including across a clock edge while held.
    repeat (2) tick();
    chk_main("rst", 4'hF, 4'h0, 4'h0, 16'd0);
    check("rst.buf_out", 32'(out_b), 32'h0);
    check("rst.sat_gcnt", 32'(gc_s), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk_main("idle", 4'hF, 4'h0, 4'h0, 16'd0);

    // Fall on ch0 (D=2): commits on the second differing sample.
    in = 4'b0001;
    tick();
    chk_main("fall.e1", 4'hF, 4'h0, 4'h1, 16'd0);
    tick();
    chk_main("fall.e2", 4'hE, 4'h1, 4'h0, 16'd0);
    tick();
    chk_main("fall.e3", 4'hE, 4'h0, 4'h0, 16'd0);

    // Rise on ch0 (D=3).
    in = 4'b0000;
    tick();
    chk_main("rise.e1", 4'hE, 4'h0, 4'h1, 16'd0);
    tick();
    chk_main("rise.e2", 4'hE, 4'h0, 4'h1, 16'd0);
    tick();
    chk_main("rise.e3", 4'hF, 4'h1, 4'h0, 16'd0);
    tick();
    chk_main("rise.e4", 4'hF, 4'h0, 4'h0, 16'd0);

    // Single-sample glitch on ch1.
    in = 4'b0010;
    tick();
    chk_main("gl1.e1", 4'hF, 4'h0, 4'h2, 16'd0);
    in = 4'b0000;
    tick();
    chk_main("gl1.e2", 4'hF, 4'h0, 4'h0, 16'd1);

    // Drop ch0, then a two-sample rise attempt that is too short.
    in = 4'b0001;
    repeat (3) tick();
    chk_main("gl2.low", 4'hE, 4'h0, 4'h0, 16'd1);
    in = 4'b0000;
    repeat (2) tick();
    chk_main("gl2.pend", 4'hE, 4'h0, 4'h1, 16'd1);
    in = 4'b0001;
    tick();
    chk_main("gl2.cancel", 4'hE, 4'h0, 4'h0, 16'd2);
    in = 4'b0000;
    repeat (3) tick();
    chk_main("gl2.restore", 4'hF, 4'h1, 4'h0, 16'd2);
    tick();

    // Three simultaneous glitches.
    in = 4'b1110;
    tick();
    chk_main("gl3.e1", 4'hF, 4'h0, 4'hE, 16'd2);
    in = 4'b0000;
    tick();
    chk_main("gl3.e2", 4'hF, 4'h0, 4'h0, 16'd5);

    // Clear on a cancel edge drops that edge's glitch.
    in = 4'b0010;
    tick();
    in = 4'b0000;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk_main("clr", 4'hF, 4'h0, 4'h0, 16'd0);
    check("clr.sat", 32'(gc_s), 32'h0);

    // Saturation: 4 bursts of 4 glitches plus one single = 17 events.
    for (int k = 0; k < 3; k++) begin
      in = 4'b1111;
      tick();
      in = 4'b0000;
      tick();
    end
    check("sat.12.main", 32'(gc_m), 32'd12);
    check("sat.12.sat", 32'(gc_s), 32'd12);
    in = 4'b1111;
    tick();
    in = 4'b0000;
    tick();
    check("sat.16.main", 32'(gc_m), 32'd16);
    check("sat.16.sat", 32'(gc_s), 32'd15);
    in = 4'b0010;
    tick();
    in = 4'b0000;
    tick();
    check("sat.17.main", 32'(gc_m), 32'd17);
    check("sat.17.sat", 32'(gc_s), 32'd15);
    tick();
    check("sat.hold", 32'(gc_s), 32'd15);

    // Reset while ch2 is pending: discarded, not counted.
    in = 4'b0100;
    tick();
    chk_main("rstp.pend", 4'hF, 4'h0, 4'h4, 16'd17);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("rstp.async", 4'hF, 4'h0, 4'h0, 16'd0);
    check("rstp.sat", 32'(gc_s), 32'h0);
    tick();
    chk_main("rstp.hold", 4'hF, 4'h0, 4'h0, 16'd0);
    rst_n = 1'b1;
    tick();
    chk_main("rstp.e1", 4'hF, 4'h0, 4'h4, 16'd0);
    tick();
    chk_main("rstp.e2", 4'hB, 4'h4, 4'h0, 16'd0);

    // Unit-delay buffer: plain register stage, back-to-back strobes.
    check("buf.init", 32'(out_b), 32'h4);
    in = 4'b0101;
    tick();
    check("buf.t1.out", 32'(out_b), 32'h5);
    check("buf.t1.chg", 32'(chg_b), 32'h1);
    in = 4'b0100;
    tick();
    check("buf.t2.out", 32'(out_b), 32'h4);
    check("buf.t2.chg", 32'(chg_b), 32'h1);
    check("buf.t2.pend", 32'(pend_b), 32'h0);
    tick();
    check("buf.t3.chg", 32'(chg_b), 32'h0);
    check("buf.gcnt", 32'(gc_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
